hh_membrane_integrator: RTL

- Other end of the Hodgkin-Huxley gating loop. The gating-variable updaters consume the membrane voltage V and produce m, h and n.
- This block consumes m, h, n and the external current I_ext. It computes the Na, K and leak ionic currents and integrates the membrane equation one Euler step per handshake.
- It drives V back to the gating updaters.
- A single shared signed multiplier is sequenced by an FSM: 10 multiplies, then one accumulate.

---
 rtl/hh_pkg.sv | 26 ++
 rtl/hh_membrane_integrator_if.sv | 26 ++
 rtl/hh_fxp_mul.sv | 30 +++
 rtl/hh_membrane_integrator.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/hh_pkg.sv
// Shared Hodgkin-Huxley fixed-point types and default membrane constants (Q8.8),
// common to the membrane integrator and the gating-variable updaters.
package hh_pkg;

  typedef logic signed [15:0] fxp16_t;

  localparam fxp16_t FXP_ONE = 16'sh0100;
  localparam fxp16_t FXP_MAX = 16'sh7FFF;
  localparam fxp16_t FXP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    HH_IDLE = 2'd0,
    HH_MUL  = 2'd1,
    HH_ACC  = 2'd2
  } hh_state_e;

  // Conductances and reversal potentials of the classic squid-axon model
  localparam fxp16_t G_NA_DEF   = 16'sh7800;
  localparam fxp16_t G_K_DEF    = 16'sh2400;
  localparam fxp16_t G_L_DEF    = 16'sh004D;
  localparam fxp16_t E_NA_DEF   = 16'sh3200;
  localparam fxp16_t E_K_DEF    = 16'shB300;
  localparam fxp16_t E_L_DEF    = 16'shC99A;
  localparam fxp16_t V_REST_DEF = 16'shBF00;

endpackage

// File: rtl/hh_membrane_integrator_if.sv
// Step handshake and membrane-voltage bus between the gating loop and the integrator.
interface hh_membrane_integrator_if import hh_pkg::*; ();

  logic   in_valid;
  logic   in_ready;
  fxp16_t m;
  fxp16_t h;
  fxp16_t n;
  fxp16_t i_ext;
  logic   v_load;
  fxp16_t v_load_value;
  fxp16_t v;
  logic   v_valid;
  logic   sat;

  modport master (
    output in_valid, m, h, n, i_ext, v_load, v_load_value,
    input  in_ready, v, v_valid, sat
  );

  modport slave (
    input  in_valid, m, h, n, i_ext, v_load, v_load_value,
    output in_ready, v, v_valid, sat
  );

endinterface

// File: rtl/hh_fxp_mul.sv
// Combinational Q8.8 signed multiply: full product, floor shift by 8, clamp to 16 bits.
module hh_fxp_mul import hh_pkg::*; (
  input  fxp16_t a,
  input  fxp16_t b,
  output fxp16_t p,
  output logic   ovf
);

  logic signed [31:0] a_x;
  logic signed [31:0] b_x;
  logic signed [31:0] prod;
  logic signed [31:0] shr;

  always_comb begin
    a_x  = 32'(a);
    b_x  = 32'(b);
    prod = a_x * b_x;
    shr  = prod >>> 8;
    ovf  = 1'b0;
    p    = shr[15:0];
    if (shr > 32'sd32767) begin
      p   = FXP_MAX;
      ovf = 1'b1;
    end else if (shr < -32'sd32768) begin
      p   = FXP_MIN;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/hh_membrane_integrator.sv
// One forward-Euler step of the HH membrane equation per accepted handshake,
// sequencing ten multiplies through a single shared multiplier.
module hh_membrane_integrator import hh_pkg::*; #(
  parameter fxp16_t G_NA     = G_NA_DEF,
  parameter fxp16_t G_K      = G_K_DEF,
  parameter fxp16_t G_L      = G_L_DEF,
  parameter fxp16_t E_NA     = E_NA_DEF,
  parameter fxp16_t E_K      = E_K_DEF,
  parameter fxp16_t E_L      = E_L_DEF,
  parameter fxp16_t V_REST   = V_REST_DEF,
  parameter int     DT_SHIFT = 4
) (
  input logic                     clk,
  input logic                     rst,
  hh_membrane_integrator_if.slave bus
);

  localparam logic [1:0] IDLE = HH_IDLE;
  localparam logic [1:0] MUL  = HH_MUL;
  localparam logic [1:0] ACC  = HH_ACC;

  function automatic logic signed [18:0] ext19(input fxp16_t x);
    return {{3{x[15]}}, x};
  endfunction

  function automatic logic clip16(input logic signed [18:0] x);
    return (x > 19'sd32767) || (x < -19'sd32768);
  endfunction

  function automatic fxp16_t sat16(input logic signed [18:0] x);
    if (x > 19'sd32767)       return FXP_MAX;
    else if (x < -19'sd32768) return FXP_MIN;
    else                      return x[15:0];
  endfunction

  logic [1:0] state;
  logic [3:0] step;
  fxp16_t     v_r;
  logic       vld_r;
  logic       sat_r;
  fxp16_t     m_r, h_r, n_r, iext_r;
  fxp16_t     m2, m3, t, ina, n2, n4, ik, il;

  fxp16_t             e_sel, dv, op_a, op_b, prod, s_sat, s_step;
  logic               dv_used, mul_ovf, sub_ovf, acc_ovf;
  logic signed [18:0] dv_w, s_w, v_w;

  // Reversal potential for the driving-force term of the current step
  always_comb begin
    e_sel = E_L;
    case (step)
      4'd4:    e_sel = E_NA;
      4'd8:    e_sel = E_K;
      default: e_sel = E_L;
    endcase
  end

  assign dv_w    = ext19(v_r) - ext19(e_sel);
  assign dv      = sat16(dv_w);
  assign sub_ovf = clip16(dv_w);

  always_comb begin
    op_a    = m_r;
    op_b    = m_r;
    dv_used = 1'b0;
    case (step)
      4'd0: begin op_a = m_r; op_b = m_r;  end
      4'd1: begin op_a = m2;  op_b = m_r;  end
      4'd2: begin op_a = m3;  op_b = h_r;  end
      4'd3: begin op_a = t;   op_b = G_NA; end
      4'd4: begin op_a = t;   op_b = dv;   dv_used = 1'b1; end
      4'd5: begin op_a = n_r; op_b = n_r;  end
      4'd6: begin op_a = n2;  op_b = n2;   end
      4'd7: begin op_a = n4;  op_b = G_K;  end
      4'd8: begin op_a = t;   op_b = dv;   dv_used = 1'b1; end
      4'd9: begin op_a = G_L; op_b = dv;   dv_used = 1'b1; end
      default: begin op_a = m_r; op_b = m_r; end
    endcase
  end

  hh_fxp_mul u_mul (
    .a   (op_a),
    .b   (op_b),
    .p   (prod),
    .ovf (mul_ovf)
  );

  // Ionic currents are summed at 19 bits so only the final sum is clamped
  assign s_w     = ext19(iext_r) - ext19(ina) - ext19(ik) - ext19(il);
  assign s_sat   = sat16(s_w);
  assign s_step  = s_sat >>> DT_SHIFT;
  assign v_w     = ext19(v_r) + ext19(s_step);
  assign acc_ovf = clip16(s_w) | clip16(v_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 4'd0;
      v_r    <= V_REST;
      vld_r  <= 1'b0;
      sat_r  <= 1'b0;
      m_r    <= '0; h_r <= '0; n_r <= '0; iext_r <= '0;
      m2     <= '0; m3  <= '0; t   <= '0; ina    <= '0;
      n2     <= '0; n4  <= '0; ik  <= '0; il     <= '0;
    end else begin
      vld_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.v_load) begin
            v_r   <= bus.v_load_value;
            sat_r <= 1'b0;
          end else if (bus.in_valid) begin
            m_r    <= bus.m;
            h_r    <= bus.h;
            n_r    <= bus.n;
            iext_r <= bus.i_ext;
            sat_r  <= 1'b0;
            step   <= 4'd0;
            state  <= MUL;
          end
        end
        MUL: begin
          sat_r <= sat_r | mul_ovf | (dv_used & sub_ovf);
          case (step)
            4'd0:             m2  <= prod;
            4'd1:             m3  <= prod;
            4'd2, 4'd3, 4'd7: t   <= prod;
            4'd4:             ina <= prod;
            4'd5:             n2  <= prod;
            4'd6:             n4  <= prod;
            4'd8:             ik  <= prod;
            4'd9:             il  <= prod;
            default: ;
          endcase
          if (step == 4'd9) begin
            step  <= 4'd0;
            state <= ACC;
          end else begin
            step <= step + 4'd1;
          end
        end
        ACC: begin
          v_r   <= sat16(v_w);
          sat_r <= sat_r | acc_ovf;
          vld_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == IDLE) & ~bus.v_load;
  assign bus.v        = v_r;
  assign bus.v_valid  = vld_r;
  assign bus.sat      = sat_r;

endmodule
